// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Mode selectors for the FWFT parameter and the pointer-width function.
package sync_fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Smallest w with 2**w >= depth.
    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one read port
// whose output register loads only when re_i is high. No reset on contents.
module sync_fifo_ram #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO with registered occupancy flags and either a
// read-latency-1 output or a first-word-fall-through output.
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 64,
    parameter int FWFT  = MODE_STD,
    parameter int AFVAL = DEPTH - 4,
    parameter int AEVAL = 4,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA,
    input  logic             WE,
    input  logic             RE,
    output logic [WIDTH-1:0] Q,
    output logic             DVLD,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic [AW:0]      COUNT
);

    if ((DEPTH < 4) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_fwft: DEPTH must be a power of two in 4..4096");
    end
    if ((WIDTH < 1) || (WIDTH > 64) || ((FWFT != MODE_STD) && (FWFT != MODE_FWFT))) begin : g_bad_mode
        $fatal(1, "sync_fifo_fwft: WIDTH must be 1..64 and FWFT 0 or 1");
    end
    if ((AEVAL < 1) || (AFVAL > DEPTH - 1) || (AEVAL >= AFVAL)) begin : g_bad_thresh
        $fatal(1, "sync_fifo_fwft: need 1 <= AEVAL < AFVAL <= DEPTH-1");
    end

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AFVAL_C = AFVAL[AW:0];
    localparam logic [AW:0] AEVAL_C = AEVAL[AW:0];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             ovf_q, udf_q, dvld_q;
    logic             byp_q, byp_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;
    logic             wr_acc, rd_acc, bypass;
    logic             ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    // A request is taken only when the registered flag allows it and RESET is low.
    assign wr_acc = WE & ~full_q & ~RESET;
    assign rd_acc = RE & ~empty_q & ~RESET;

    // FWFT: the word being written becomes the head when nothing else remains,
    // so it goes straight to the output register instead of waiting on the RAM.
    assign bypass = (FWFT == MODE_FWFT) && wr_acc && (count_q == {{AW{1'b0}}, rd_acc});

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (bypass) begin
            byp_d      = 1'b1;
            byp_data_d = DATA;
        end else if (rd_acc) begin
            byp_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            dvld_q     <= 1'b0;
            byp_q      <= 1'b1;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            afull_q    <= (count_d >= AFVAL_C);
            aempty_q   <= (count_d <= AEVAL_C);
            ovf_q      <= WE & full_q;
            udf_q      <= RE & empty_q;
            dvld_q     <= rd_acc;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    // FWFT reads ahead at the next head address every cycle; standard mode
    // loads the output register only on an accepted read.
    assign ram_re    = (FWFT == MODE_FWFT) ? 1'b1 : rd_acc;
    assign ram_raddr = (FWFT == MODE_FWFT) ? rd_ptr_d : rd_ptr_q;

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (DATA),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign Q         = byp_q ? byp_data_q : ram_rdata;
    assign DVLD      = (FWFT == MODE_FWFT) ? ~empty_q : dvld_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign AFULL     = afull_q;
    assign AEMPTY    = aempty_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: four configurations share one stimulus stream and
// are each compared every cycle against a queue-based model, plus directed checks.
module tb_sync_fifo_fwft;

    localparam int W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, we, re;
    logic [W-1:0] data;

    logic [W-1:0] q_w[4];
    logic         dvld_w[4], full_w[4], empty_w[4], afull_w[4], aempty_w[4], ovf_w[4], udf_w[4];
    logic [6:0]   cnt64[2];
    logic [2:0]   cnt4[2];

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(64), .FWFT(0)) u_s64 (
        .CLK(clk), .RESET(rst), .DATA(data), .WE(we), .RE(re), .Q(q_w[0]), .DVLD(dvld_w[0]),
        .FULL(full_w[0]), .EMPTY(empty_w[0]), .AFULL(afull_w[0]), .AEMPTY(aempty_w[0]),
        .OVERFLOW(ovf_w[0]), .UNDERFLOW(udf_w[0]), .COUNT(cnt64[0]));
    sync_fifo_fwft #(.WIDTH(W), .DEPTH(64), .FWFT(1)) u_f64 (
        .CLK(clk), .RESET(rst), .DATA(data), .WE(we), .RE(re), .Q(q_w[1]), .DVLD(dvld_w[1]),
        .FULL(full_w[1]), .EMPTY(empty_w[1]), .AFULL(afull_w[1]), .AEMPTY(aempty_w[1]),
        .OVERFLOW(ovf_w[1]), .UNDERFLOW(udf_w[1]), .COUNT(cnt64[1]));
    sync_fifo_fwft #(.WIDTH(W), .DEPTH(4), .FWFT(0), .AFVAL(3), .AEVAL(1)) u_s4 (
        .CLK(clk), .RESET(rst), .DATA(data), .WE(we), .RE(re), .Q(q_w[2]), .DVLD(dvld_w[2]),
        .FULL(full_w[2]), .EMPTY(empty_w[2]), .AFULL(afull_w[2]), .AEMPTY(aempty_w[2]),
        .OVERFLOW(ovf_w[2]), .UNDERFLOW(udf_w[2]), .COUNT(cnt4[0]));
    sync_fifo_fwft #(.WIDTH(W), .DEPTH(4), .FWFT(1), .AFVAL(3), .AEVAL(1)) u_f4 (
        .CLK(clk), .RESET(rst), .DATA(data), .WE(we), .RE(re), .Q(q_w[3]), .DVLD(dvld_w[3]),
        .FULL(full_w[3]), .EMPTY(empty_w[3]), .AFULL(afull_w[3]), .AEMPTY(aempty_w[3]),
        .OVERFLOW(ovf_w[3]), .UNDERFLOW(udf_w[3]), .COUNT(cnt4[1]));

    // Reference model: one queue per instance plus the registered pulses.
    int           m_depth[4] = '{64, 64, 4, 4};
    int           m_fwft[4]  = '{0, 1, 0, 1};
    int           m_af[4]    = '{60, 60, 3, 3};
    int           m_ae[4]    = '{4, 4, 1, 1};
    logic [W-1:0] exp_q[4][$];
    logic [W-1:0] m_last[4];
    bit           m_dvld[4], m_ovf[4], m_udf[4], m_rst[4];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t: got=%h want=%h", name, $time, act, want);
        end
    endtask

    function automatic logic [63:0] pack(input logic [7:0] c, input logic [6:0] f, input logic [W-1:0] q);
        return {31'b0, c, f, q};
    endfunction

    function automatic logic [63:0] obs(input int i, input bit qchk);
        logic [7:0] c;
        case (i)
            0:       c = {1'b0, cnt64[0]};
            1:       c = {1'b0, cnt64[1]};
            2:       c = {5'b0, cnt4[0]};
            default: c = {5'b0, cnt4[1]};
        endcase
        return pack(c, {full_w[i], empty_w[i], afull_w[i], aempty_w[i], ovf_w[i], udf_w[i], dvld_w[i]},
                    qchk ? q_w[i] : '0);
    endfunction

    task automatic model_update();
        bit is_full, is_empty;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                exp_q[i].delete();
                m_last[i] = '0;
                m_dvld[i] = 1'b0;
                m_ovf[i]  = 1'b0;
                m_udf[i]  = 1'b0;
                m_rst[i]  = 1'b1;
            end else begin
                is_full   = (exp_q[i].size() == m_depth[i]);
                is_empty  = (exp_q[i].size() == 0);
                m_ovf[i]  = we && is_full;
                m_udf[i]  = re && is_empty;
                m_dvld[i] = re && !is_empty;
                m_rst[i]  = 1'b0;
                if (re && !is_empty) m_last[i] = exp_q[i].pop_front();
                if (we && !is_full) exp_q[i].push_back(data);
            end
        end
    endtask

    task automatic model_check();
        int           sz;
        bit           qchk, edvld;
        logic [W-1:0] qexp;
        for (int i = 0; i < 4; i++) begin
            sz = exp_q[i].size();
            if (m_fwft[i] == 0) begin
                qchk  = 1'b1;
                qexp  = m_last[i];
                edvld = m_dvld[i];
            end else begin
                edvld = (sz > 0);
                qchk  = m_rst[i] || (sz > 0);
                qexp  = (sz > 0) ? exp_q[i][0] : '0;
            end
            chk($sformatf("cyc_u%0d", i), obs(i, qchk),
                pack(8'(sz), {sz == m_depth[i], sz == 0, sz >= m_af[i], sz <= m_ae[i],
                              m_ovf[i], m_udf[i], edvld}, qexp));
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
        rst  = r;
        we   = w;
        re   = rd;
        data = d;
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    typedef struct {
        bit           rst, we, re;
        logic [W-1:0] d;
        int           cnt;
        logic [6:0]   flags;   // full, empty, afull, aempty, ovf, udf, dvld
        logic [W-1:0] q;
    } vec_t;

    vec_t vt[10];
    int   pw, pr;

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; data = '0;

        // Directed vectors against the standard-mode DEPTH=64 instance.
        vt[0] = '{1, 0, 0, 18'h000, 0, 7'b0101000, 18'h000};
        vt[1] = '{0, 1, 0, 18'h111, 1, 7'b0001000, 18'h000};
        vt[2] = '{0, 1, 1, 18'h222, 1, 7'b0001001, 18'h111};
        vt[3] = '{0, 0, 0, 18'h000, 1, 7'b0001000, 18'h111};
        vt[4] = '{0, 0, 1, 18'h000, 0, 7'b0101001, 18'h222};
        vt[5] = '{0, 0, 1, 18'h000, 0, 7'b0101010, 18'h222};
        vt[6] = '{0, 1, 1, 18'h333, 1, 7'b0001010, 18'h222};
        vt[7] = '{0, 0, 0, 18'h000, 1, 7'b0001000, 18'h222};
        vt[8] = '{1, 1, 0, 18'h3ff, 0, 7'b0101000, 18'h000};
        vt[9] = '{0, 0, 1, 18'h000, 0, 7'b0101010, 18'h000};
        for (int k = 0; k < 10; k++) begin
            step(vt[k].rst, vt[k].we, vt[k].re, vt[k].d);
            chk($sformatf("vec%0d", k), obs(0, 1'b1), pack(vt[k].cnt[7:0], vt[k].flags, vt[k].q));
        end

        // Fill to full, overflow, drain in order, underflow.
        step(1, 0, 0, '0);
        for (int k = 0; k < 64; k++) begin
            step(0, 1, 0, W'(k));
            if (k == 58) chk("afull_at59", afull_w[0], 1'b0);
            if (k == 59) chk("afull_at60", afull_w[0], 1'b1);
            if (k == 62) chk("full_at63", full_w[0], 1'b0);
        end
        chk("full_at64", {full_w[0], cnt64[0]}, {1'b1, 7'd64});
        step(0, 1, 0, 18'h3ffff);
        chk("ovf_pulse", {ovf_w[0], cnt64[0]}, {1'b1, 7'd64});
        step(0, 0, 0, '0);
        chk("ovf_clear", ovf_w[0], 1'b0);
        for (int k = 0; k < 64; k++) begin
            step(0, 0, 1, '0);
            chk($sformatf("drain_%0d", k), {dvld_w[0], q_w[0]}, {1'b1, W'(k)});
            if (k == 58) chk("aempty_at5", aempty_w[0], 1'b0);
            if (k == 59) chk("aempty_at4", aempty_w[0], 1'b1);
        end
        step(0, 0, 1, '0);
        chk("udf_pulse", {udf_w[0], empty_w[0], dvld_w[0]}, {1'b1, 1'b1, 1'b0});

        // FWFT: single write falls through without RE.
        step(1, 0, 0, '0);
        step(0, 1, 0, 18'h2a5);
        chk("fwft_fall", {empty_w[1], dvld_w[1], q_w[1]}, {1'b0, 1'b1, 18'h2a5});
        step(0, 0, 1, '0);
        chk("fwft_pop", empty_w[1], 1'b1);

        // FWFT streaming at occupancy 3 across pointer wrap.
        step(1, 0, 0, '0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, W'(k));
        for (int k = 0; k < 200; k++) begin
            step(0, 1, 1, W'(k + 3));
            chk($sformatf("tput_%0d", k), {cnt64[1], dvld_w[1], q_w[1]}, {7'd3, 1'b1, W'(k + 1)});
        end

        // Reset mid-burst with WE=RE=1.
        step(1, 0, 0, '0);
        for (int k = 0; k < 40; k++) step(0, 1, 0, W'(18'h100 + k));
        for (int k = 0; k < 3; k++) step(0, 1, 1, W'(18'h200 + k));
        step(1, 1, 1, 18'h3ffff);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_u%0d", i), obs(i, 1'b1), pack(8'd0, 7'b0101000, '0));
        end
        for (int k = 0; k < 4; k++) step(0, 1, 0, W'(18'h500 + k));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post_rst_f%0d", k), q_w[1], W'(18'h500 + k));
            step(0, 0, 1, '0);
            chk($sformatf("post_rst_s%0d", k), q_w[0], W'(18'h500 + k));
        end

        // Randomized traffic with drifting write/read pressure.
        pw = 50;
        pr = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 250 == 0) begin
                pw = $urandom_range(15, 85);
                pr = $urandom_range(15, 85);
            end
            step($urandom_range(0, 599) == 0, $urandom_range(0, 99) < pw,
                 $urandom_range(0, 99) < pr, W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
